// File: rtl/avalon_mm_clock_crossing_bridge.sv
// Avalon-MM clock-crossing bridge: commands cross slave_clk -> master_clk and read responses
// return through gray-pointer async FIFOs; read credits bound outstanding reads to RSP_DEPTH.
module avalon_mm_clock_crossing_bridge #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 23,
    parameter int CMD_DEPTH   = 16,
    parameter int RSP_DEPTH   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                 slave_clk,
    input  logic                                 slave_reset_n,
    input  logic                                 master_clk,
    input  logic                                 master_reset_n,
    input  logic [ADDR_W-1:0]                    slave_address,
    input  logic [DATA_W/8-1:0]                  slave_byteenable,
    input  logic                                 slave_read,
    input  logic                                 slave_write,
    input  logic [DATA_W-1:0]                    slave_writedata,
    output logic                                 slave_waitrequest,
    output logic [DATA_W-1:0]                    slave_readdata,
    output logic                                 slave_readdatavalid,
    output logic [ADDR_W+$clog2(DATA_W/8)-1:0]   master_address,
    output logic [DATA_W/8-1:0]                  master_byteenable,
    output logic                                 master_read,
    output logic                                 master_write,
    output logic [DATA_W-1:0]                    master_writedata,
    input  logic                                 master_waitrequest,
    input  logic [DATA_W-1:0]                    master_readdata,
    input  logic                                 master_readdatavalid
);
    localparam int BE_W = DATA_W / 8;
    localparam int BOFF = $clog2(BE_W);
    localparam int MA_W = ADDR_W + BOFF;
    localparam int CAW  = $clog2(CMD_DEPTH);
    localparam int CPW  = CAW + 1;
    localparam int RAW  = $clog2(RSP_DEPTH);
    localparam int RPW  = RAW + 1;
    localparam logic [CPW-1:0] CFULL = {2'b11, {(CPW-2){1'b0}}};

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic {IDLE, ISSUE} state_t;

    function automatic logic [CPW-1:0] cgray(input logic [CPW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [RPW-1:0] rgray(input logic [RPW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    cmd_t              cmd_mem [CMD_DEPTH];
    logic [DATA_W-1:0] rsp_mem [RSP_DEPTH];

    // ---------------- slave domain ----------------
    logic [CPW-1:0]                    cmd_wbin_q, cmd_wbin_d, cmd_wgray_q;
    logic [SYNC_STAGES-1:0][CPW-1:0]   cmd_rgray_sync_q;
    logic [RPW-1:0]                    rsp_rbin_q, rsp_rbin_d, rsp_rgray_q;
    logic [SYNC_STAGES-1:0][RPW-1:0]   rsp_wgray_sync_q;
    logic [RPW-1:0]                    credit_q, credit_d;
    logic                              rvalid_q;
    logic [DATA_W-1:0]                 rdata_q;
    logic                              cmd_full, cmd_push, rd_acc, rsp_empty, rsp_pop;
    cmd_t                              in_cmd;

    // Simultaneous read+write is resolved as a write.
    always_comb begin
        in_cmd.rd    = slave_read & ~slave_write;
        in_cmd.wr    = slave_write;
        in_cmd.addr  = slave_address;
        in_cmd.be    = slave_byteenable;
        in_cmd.wdata = slave_writedata;
    end

    assign cmd_full          = (cmd_wgray_q == (cmd_rgray_sync_q[SYNC_STAGES-1] ^ CFULL));
    assign slave_waitrequest = cmd_full | (slave_read & (credit_q == RPW'(RSP_DEPTH)));
    assign cmd_push          = (slave_read | slave_write) & ~slave_waitrequest;
    assign rd_acc            = cmd_push & in_cmd.rd;
    assign rsp_empty         = (rsp_rgray_q == rsp_wgray_sync_q[SYNC_STAGES-1]);
    assign rsp_pop           = ~rsp_empty;

    always_comb begin
        cmd_wbin_d = cmd_wbin_q + CPW'(cmd_push);
        rsp_rbin_d = rsp_rbin_q + RPW'(rsp_pop);
        credit_d   = credit_q;
        case ({rd_acc, rvalid_q})
            2'b10:   credit_d = credit_q + 1'b1;
            2'b01:   credit_d = credit_q - 1'b1;
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge slave_clk)
        if (cmd_push) cmd_mem[cmd_wbin_q[CAW-1:0]] <= in_cmd;

    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            cmd_wbin_q       <= '0;
            cmd_wgray_q      <= '0;
            cmd_rgray_sync_q <= '0;
            rsp_rbin_q       <= '0;
            rsp_rgray_q      <= '0;
            rsp_wgray_sync_q <= '0;
            credit_q         <= '0;
            rvalid_q         <= 1'b0;
            rdata_q          <= '0;
        end else begin
            cmd_wbin_q       <= cmd_wbin_d;
            cmd_wgray_q      <= cgray(cmd_wbin_d);
            cmd_rgray_sync_q <= {cmd_rgray_sync_q[SYNC_STAGES-2:0], cmd_rgray_q};
            rsp_rbin_q       <= rsp_rbin_d;
            rsp_rgray_q      <= rgray(rsp_rbin_d);
            rsp_wgray_sync_q <= {rsp_wgray_sync_q[SYNC_STAGES-2:0], rsp_wgray_q};
            credit_q         <= credit_d;
            rvalid_q         <= rsp_pop;
            if (rsp_pop) rdata_q <= rsp_mem[rsp_rbin_q[RAW-1:0]];
        end
    end

    assign slave_readdata      = rdata_q;
    assign slave_readdatavalid = rvalid_q;

    // ---------------- master domain ----------------
    logic [CPW-1:0]                    cmd_rbin_q, cmd_rbin_d, cmd_rgray_q;
    logic [SYNC_STAGES-1:0][CPW-1:0]   cmd_wgray_sync_q;
    logic [RPW-1:0]                    rsp_wbin_q, rsp_wbin_d, rsp_wgray_q;
    cmd_t                              cmd_q;
    state_t                            state_q, state_d;
    logic                              cmd_empty, cmd_pop;

    assign cmd_empty = (cmd_rgray_q == cmd_wgray_sync_q[SYNC_STAGES-1]);

    always_ff @(posedge master_clk or negedge master_reset_n)
        if (!master_reset_n) state_q <= IDLE;
        else                 state_q <= state_d;

    // In ISSUE the next entry is popped on the acceptance edge for 1 cmd/cycle throughput.
    always_comb begin
        state_d = state_q;
        cmd_pop = 1'b0;
        case (state_q)
            IDLE: if (!cmd_empty) begin
                cmd_pop = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: if (!master_waitrequest) begin
                if (!cmd_empty) cmd_pop = 1'b1;
                else            state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_rbin_d = cmd_rbin_q + CPW'(cmd_pop);
        rsp_wbin_d = rsp_wbin_q + RPW'(master_readdatavalid);
    end

    // No full check: the slave-side credit limit guarantees room.
    always_ff @(posedge master_clk)
        if (master_readdatavalid) rsp_mem[rsp_wbin_q[RAW-1:0]] <= master_readdata;

    always_ff @(posedge master_clk or negedge master_reset_n) begin
        if (!master_reset_n) begin
            cmd_rbin_q       <= '0;
            cmd_rgray_q      <= '0;
            cmd_wgray_sync_q <= '0;
            rsp_wbin_q       <= '0;
            rsp_wgray_q      <= '0;
            cmd_q            <= '0;
        end else begin
            cmd_rbin_q       <= cmd_rbin_d;
            cmd_rgray_q      <= cgray(cmd_rbin_d);
            cmd_wgray_sync_q <= {cmd_wgray_sync_q[SYNC_STAGES-2:0], cmd_wgray_q};
            rsp_wbin_q       <= rsp_wbin_d;
            rsp_wgray_q      <= rgray(rsp_wbin_d);
            if (cmd_pop) cmd_q <= cmd_mem[cmd_rbin_q[CAW-1:0]];
        end
    end

    assign master_read       = (state_q == ISSUE) & cmd_q.rd;
    assign master_write      = (state_q == ISSUE) & cmd_q.wr;
    assign master_address    = MA_W'(cmd_q.addr) << BOFF;
    assign master_byteenable = cmd_q.be;
    assign master_writedata  = cmd_q.wdata;

endmodule

// File: tb/tb_avalon_mm_clock_crossing_bridge.sv
// Directed bench for the Avalon-MM clock-crossing bridge: command and read-data scoreboards,
// a bench-side memory model on the master port, and a 64-bit instance for width checks.
module tb_avalon_mm_clock_crossing_bridge;
    logic sclk, mclk, srst_n, mrst_n;

    logic [22:0] s_addr;  logic [3:0] s_be;  logic s_rd, s_wr;  logic [31:0] s_wdata;
    logic        s_wait;  logic [31:0] s_rdata;  logic s_rv;
    logic [24:0] m_addr;  logic [3:0] m_be;  logic m_rd, m_wr;  logic [31:0] m_wdata;
    logic        m_wait;  logic [31:0] m_rdata;  logic m_rv;

    logic [19:0] x_addr;  logic [7:0] x_be;  logic x_rd, x_wr;  logic [63:0] x_wdata;
    logic        x_wait;  logic [63:0] x_rdata;  logic x_rv;
    logic [22:0] xm_addr; logic [7:0] xm_be; logic xm_rd, xm_wr; logic [63:0] xm_wdata;
    logic        xm_wait; logic [63:0] xm_rdata; logic xm_rv;

    avalon_mm_clock_crossing_bridge dut (
        .slave_clk(sclk), .slave_reset_n(srst_n), .master_clk(mclk), .master_reset_n(mrst_n),
        .slave_address(s_addr), .slave_byteenable(s_be), .slave_read(s_rd), .slave_write(s_wr),
        .slave_writedata(s_wdata), .slave_waitrequest(s_wait), .slave_readdata(s_rdata),
        .slave_readdatavalid(s_rv), .master_address(m_addr), .master_byteenable(m_be),
        .master_read(m_rd), .master_write(m_wr), .master_writedata(m_wdata),
        .master_waitrequest(m_wait), .master_readdata(m_rdata), .master_readdatavalid(m_rv));

    avalon_mm_clock_crossing_bridge #(.DATA_W(64), .ADDR_W(20)) dut64 (
        .slave_clk(sclk), .slave_reset_n(srst_n), .master_clk(mclk), .master_reset_n(mrst_n),
        .slave_address(x_addr), .slave_byteenable(x_be), .slave_read(x_rd), .slave_write(x_wr),
        .slave_writedata(x_wdata), .slave_waitrequest(x_wait), .slave_readdata(x_rdata),
        .slave_readdatavalid(x_rv), .master_address(xm_addr), .master_byteenable(xm_be),
        .master_read(xm_rd), .master_write(xm_wr), .master_writedata(xm_wdata),
        .master_waitrequest(xm_wait), .master_readdata(xm_rdata), .master_readdatavalid(xm_rv));

    initial begin sclk = 0; forever #5 sclk = ~sclk; end
    initial begin mclk = 0; forever #14 mclk = ~mclk; end

    typedef struct { bit rd; logic [22:0] addr; logic [3:0] be; logic [31:0] wdata; } exp_cmd_t;
    exp_cmd_t    exp_cmd[$];
    logic [31:0] exp_rsp[$];
    logic [31:0] pend[$];
    int n_chk = 0, n_fail = 0, mst_cnt = 0;
    bit stall = 0, hold_rsp = 0;

    function automatic logic [31:0] rdmem(input logic [22:0] a);
        return {9'h1A5, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Master-side memory model: checks issued commands, returns read data in order.
    initial begin
        m_wait = 0; m_rv = 0; m_rdata = '0;
        forever begin
            @(negedge mclk);
            if (!mrst_n) begin
                pend.delete(); m_rv = 0; m_wait = stall;
                continue;
            end
            if (!hold_rsp && pend.size() > 0) begin m_rv = 1; m_rdata = pend.pop_front(); end
            else begin m_rv = 0; m_rdata = '0; end
            m_wait = stall;
            if ((m_rd || m_wr) && !m_wait) begin
                mst_cnt++;
                if (exp_cmd.size() == 0) chk("mst_extra_cmd", 1, 0);
                else begin
                    exp_cmd_t e;
                    e = exp_cmd.pop_front();
                    chk("mst_cmd", {1'b0, m_rd, m_wr, m_addr, m_be, m_wdata},
                        {1'b0, e.rd, ~e.rd, e.addr, 2'b00, e.be, e.wdata});
                end
                if (m_rd) pend.push_back(rdmem(m_addr[24:2]));
            end
        end
    end

    // Slave-side read-data scoreboard.
    initial begin
        forever begin
            @(negedge sclk);
            if (srst_n && s_rv) begin
                if (exp_rsp.size() == 0) chk("rsp_extra", 1, 0);
                else chk("rsp_data", s_rdata, exp_rsp.pop_front());
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Entered and left on a slave_clk negedge.
    task automatic send(input bit rd, input logic [22:0] a, input logic [31:0] d,
                        input logic [3:0] be, output int waited);
        exp_cmd_t e;
        s_rd = rd; s_wr = !rd; s_addr = a; s_wdata = rd ? 32'h0 : d; s_be = be;
        waited = 0;
        #1;
        while (s_wait && waited < 3000) begin @(negedge sclk); #1; waited++; end
        if (waited >= 3000) chk("send_timeout", 1, 0);
        else begin
            e.rd = rd; e.addr = a; e.be = be; e.wdata = rd ? 32'h0 : d;
            exp_cmd.push_back(e);
            if (rd) exp_rsp.push_back(rdmem(a));
        end
        @(negedge sclk);
    endtask

    task automatic idle(input int n);
        s_rd = 0; s_wr = 0;
        repeat (n) @(negedge sclk);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_cmd.size() > 0 || exp_rsp.size() > 0) && n < 5000) begin
            @(negedge sclk); n++;
        end
        chk(tag, 64'(exp_cmd.size() + exp_rsp.size()), 0);
    endtask

    initial begin
        int w, c0, n;
        srst_n = 0; mrst_n = 0;
        s_addr = '0; s_be = '0; s_rd = 0; s_wr = 0; s_wdata = '0;
        x_addr = '0; x_be = '0; x_rd = 0; x_wr = 0; x_wdata = '0;
        xm_wait = 0; xm_rdata = '0; xm_rv = 0;
        repeat (4) @(negedge sclk);
        chk("rst_slave", {s_wait, s_rv, s_rdata}, 0);
        chk("rst_master", {m_rd, m_wr, m_addr, m_be, m_wdata}, 0);
        chk("rst_credit", 64'(dut.credit_q), 0);
        srst_n = 1; mrst_n = 1;
        repeat (4) @(negedge sclk);

        // 40 writes, in order, exact data and byteenables
        c0 = mst_cnt;
        for (int i = 0; i < 40; i++)
            send(0, 23'h10 + 23'(i), 32'hC0DE0000 + 32'(i), 4'((i % 15) + 1), w);
        idle(2);
        wait_drain("wr40_drain");
        chk("wr40_count", 64'(mst_cnt - c0), 40);

        // Reads with responses withheld: credits climb to 32, then waitrequest
        hold_rsp = 1;
        for (int i = 0; i < 32; i++) begin
            send(1, 23'h100 + 23'(i), 0, 4'hF, w);
            chk("rd_nowait", 64'(w), 0);
            idle(3);
        end
        idle(20);
        chk("credit_32", 64'(dut.credit_q), 32);
        s_rd = 1; s_wr = 0; s_addr = 23'h120; s_be = 4'hF; s_wdata = '0;
        #1;
        chk("wait_at_32", s_wait, 1);
        repeat (5) @(negedge sclk);
        #1;
        chk("wait_hold_32", s_wait, 1);
        @(negedge sclk);
        hold_rsp = 0;
        for (int i = 32; i < 64; i++) send(1, 23'h100 + 23'(i), 0, 4'hF, w);
        idle(2);
        wait_drain("rd64_drain");
        repeat (3) @(negedge sclk);
        chk("credit_0", 64'(dut.credit_q), 0);

        // Master stall: fields hold, command FIFO fills
        stall = 1;
        for (int i = 0; i < 17; i++) send(0, 23'h200 + 23'(i), 32'h57000000 + 32'(i), 4'hF, w);
        s_wr = 1; s_rd = 0; s_addr = 23'h211; s_wdata = 32'h57000011; s_be = 4'hF;
        repeat (20) @(negedge sclk);
        #1;
        chk("cmd_full_wait", s_wait, 1);
        s_wr = 0;
        for (int j = 0; j < 50; j++) begin
            @(negedge mclk);
            chk("stall_hold", {m_rd, m_wr, m_addr, m_be, m_wdata},
                {1'b0, 1'b1, 23'h200, 2'b00, 4'hF, 32'h57000000});
        end
        stall = 0;
        @(negedge sclk);
        send(0, 23'h211, 32'h57000011, 4'hF, w);
        idle(2);
        wait_drain("stall_drain");

        // Read accepted in the same cycle as readdatavalid at credits=5
        stall = 1;
        for (int i = 0; i < 5; i++) send(1, 23'h300 + 23'(i), 0, 4'hF, w);
        idle(10);
        chk("credit_5_pre", 64'(dut.credit_q), 5);
        stall = 0;
        n = 0;
        while (!s_rv && n < 2000) begin @(negedge sclk); n++; end
        chk("rv_seen", s_rv, 1);
        chk("credit_5_at", 64'(dut.credit_q), 5);
        send(1, 23'h305, 0, 4'hF, w);
        chk("coincide_nowait", 64'(w), 0);
        chk("credit_5_same", 64'(dut.credit_q), 5);
        idle(2);
        wait_drain("credit5_drain");

        // Reset mid-burst
        stall = 1;
        for (int i = 0; i < 7; i++) send(0, 23'h400 + 23'(i), 32'hB0000000 + 32'(i), 4'hF, w);
        idle(8);
        chk("pre_rst_issue", m_wr, 1);
        srst_n = 0; mrst_n = 0;
        exp_cmd.delete(); exp_rsp.delete();
        #1;
        chk("mid_rst_slave", {s_wait, s_rv, s_rdata}, 0);
        chk("mid_rst_master", {m_rd, m_wr, m_addr, m_be, m_wdata}, 0);
        chk("mid_rst_credit", 64'(dut.credit_q), 0);
        stall = 0;
        repeat (4) @(negedge sclk);
        srst_n = 1; mrst_n = 1;
        repeat (4) @(negedge sclk);
        c0 = mst_cnt;
        send(0, 23'h3, 32'hDEAD0003, 4'hF, w);
        idle(2);
        wait_drain("post_rst_drain");
        repeat (30) @(negedge sclk);
        chk("post_rst_single", 64'(mst_cnt - c0), 1);

        // 64-bit instance: byte address and 8-bit byteenable
        x_wr = 1; x_addr = 20'h5A5A5; x_wdata = 64'h0123456789ABCDEF; x_be = 8'hF0;
        #1;
        n = 0;
        while (x_wait && n < 200) begin @(negedge sclk); #1; n++; end
        @(negedge sclk);
        x_wr = 0;
        n = 0;
        while (!xm_wr && n < 200) begin @(negedge mclk); n++; end
        chk("w64_seen", xm_wr, 1);
        chk("w64_addr", 64'(xm_addr), 64'({20'h5A5A5, 3'b000}));
        chk("w64_be", 64'(xm_be), 64'hF0);
        chk("w64_data", xm_wdata, 64'h0123456789ABCDEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
